// File: rtl/multicycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_if
//
// Bundle between the multicycle control unit and its datapath.
//
// Signals:
//   OP, Funct      instruction fields from the external instruction register
//   PCWrite, IorD, IRWrite, MemWrite, RegWrite, ULASrcA, Branch
//                  1-bit datapath write enables and mux selects
//   RegDst         00 rt, 01 rd, 10 $ra
//   MemtoReg       00 ULA, 10 mem, 01 PC
//   ULASrcB        00 reg, 01 const 4, 10 imm, 11 imm<<2
//   PCSrc          00 ULA, 01 ULAOut, 10 jump target, 11 register
//   ULAControl     010 add, 110 sub, 000 and, 001 or, 011 nor, 111 slt
//   state          current FSM state code (debug LEDs)
//   done           high on the last cycle of each instruction
//   illegal        high while the FSM sits in its illegal-instruction trap
//
// Modports:
//   master  control unit side (consumes OP/Funct, drives everything else)
//   slave   datapath side (drives OP/Funct, consumes the controls)
//
// There is no valid/ready handshake on this bundle: OP/Funct are level
// inputs held stable by the instruction register from DECODE to the end of
// the instruction, and every control output is a level valid for the whole
// cycle in which it is driven.
// ---------------------------------------------------------------------------
interface multicycle_control_unit_if;
    logic [5:0] OP;
    logic [5:0] Funct;

    logic       PCWrite;
    logic       IorD;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       ULASrcA;
    logic       Branch;

    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ULASrcB;
    logic [1:0] PCSrc;
    logic [2:0] ULAControl;

    logic [3:0] state;
    logic       done;
    logic       illegal;

    modport master (
        input  OP, Funct,
        output PCWrite, IorD, IRWrite, MemWrite, RegWrite, ULASrcA, Branch,
        output RegDst, MemtoReg, ULASrcB, PCSrc, ULAControl,
        output state, done, illegal
    );

    modport slave (
        output OP, Funct,
        input  PCWrite, IorD, IRWrite, MemWrite, RegWrite, ULASrcA, Branch,
        input  RegDst, MemtoReg, ULASrcB, PCSrc, ULAControl,
        input  state, done, illegal
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore FSM controlling a multicycle MIPS-style datapath. Memory states
// (FETCH, MEMREAD, MEMWRITE) each stretch to MEM_WAIT+1 cycles; their write
// enables fire on the final cycle only.
//
// Parameters:
//   MEM_WAIT   extra wait cycles per memory access (0..15)
//
// Configuration macro:
//   JAL_JR_EN  when defined, jal (OP 000011) and jr (OP 000000 / Funct
//              001000) are executed; when undefined they trap to ILLEGAL.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset; all outputs forced low while 0
//   bus        multicycle_control_unit_if.master (OP/Funct in, controls out)
//
// State codes on bus.state:
//   0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE,
//   6 EXECUTE, 7 ALUWB, 8 BRANCH, 9 ADDIEX, 10 ADDIWB, 11 JUMP,
//   12 JAL, 13 JR, 15 ILLEGAL
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int unsigned MEM_WAIT = 0
) (
    input logic                        clk,
    input logic                        rst_n,
    multicycle_control_unit_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // Counter value on the final cycle of a memory state.
    localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_last;

    logic       funct_alu_ok;
    logic [2:0] funct_alu;

    logic       pc_write, i_or_d, ir_write, mem_write, reg_write;
    logic       ula_src_a, branch, done;
    logic [1:0] reg_dst, mem_to_reg, ula_src_b, pc_src;
    logic [2:0] ula_control;

    // R-type function field to ULA operation.
    always_comb begin
        funct_alu_ok = 1'b1;
        funct_alu    = ALU_ADD;
        case (bus.Funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b100111: funct_alu = ALU_NOR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu_ok = 1'b0;
        endcase
    end

    assign mem_last = (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = 4'd0;   // the counter only survives while a memory state waits
        pc_write    = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        ula_src_a   = 1'b0;
        branch      = 1'b0;
        done        = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        ula_src_b   = 2'b00;
        pc_src      = 2'b00;
        ula_control = 3'b000;

        case (state_q)
            S_FETCH: begin
                ula_src_b   = 2'b01;
                ula_control = ALU_ADD;
                if (mem_last) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_DECODE: begin
                ula_src_b   = 2'b11;
                ula_control = ALU_ADD;
                case (bus.OP)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_alu_ok) begin
                            state_d = S_EXECUTE;
                        end
`ifdef JAL_JR_EN
                        else if (bus.Funct == FN_JR) begin
                            state_d = S_JR;
                        end
`endif
                        else begin
                            state_d = S_ILLEGAL;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
`ifdef JAL_JR_EN
                    OP_JAL:  state_d = S_JAL;
`endif
                    default: state_d = S_ILLEGAL;
                endcase
            end

            S_MEMADR: begin
                ula_src_a   = 1'b1;
                ula_src_b   = 2'b10;
                ula_control = ALU_ADD;
                state_d     = (bus.OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end

            S_MEMREAD: begin
                i_or_d = 1'b1;
                if (mem_last) begin
                    state_d = S_MEMWB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_MEMWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b00;
                mem_to_reg = 2'b10;
                done       = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWRITE: begin
                i_or_d = 1'b1;
                if (mem_last) begin
                    mem_write = 1'b1;
                    done      = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_EXECUTE: begin
                ula_src_a   = 1'b1;
                ula_src_b   = 2'b00;
                ula_control = funct_alu;
                state_d     = S_ALUWB;
            end

            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                mem_to_reg = 2'b00;
                done       = 1'b1;
                state_d    = S_FETCH;
            end

            S_BRANCH: begin
                ula_src_a   = 1'b1;
                ula_src_b   = 2'b00;
                ula_control = ALU_SUB;
                branch      = 1'b1;
                pc_src      = 2'b01;
                done        = 1'b1;
                state_d     = S_FETCH;
            end

            S_ADDIEX: begin
                ula_src_a   = 1'b1;
                ula_src_b   = 2'b10;
                ula_control = ALU_ADD;
                state_d     = S_ADDIWB;
            end

            S_ADDIWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b00;
                mem_to_reg = 2'b00;
                done       = 1'b1;
                state_d    = S_FETCH;
            end

            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                done     = 1'b1;
                state_d  = S_FETCH;
            end

`ifdef JAL_JR_EN
            S_JAL: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b01;
                done       = 1'b1;
                state_d    = S_FETCH;
            end

            S_JR: begin
                pc_write = 1'b1;
                pc_src   = 2'b11;
                done     = 1'b1;
                state_d  = S_FETCH;
            end
`endif

            S_ILLEGAL: state_d = S_ILLEGAL;

            // Unused codes (and JAL/JR when not built in) trap like a bad opcode.
            default: state_d = S_ILLEGAL;
        endcase
    end

    // Outputs are gated by rst_n so nothing fires in the cycle reset is
    // asserted, including mid-instruction.
    assign bus.PCWrite    = rst_n & pc_write;
    assign bus.IorD       = rst_n & i_or_d;
    assign bus.IRWrite    = rst_n & ir_write;
    assign bus.MemWrite   = rst_n & mem_write;
    assign bus.RegWrite   = rst_n & reg_write;
    assign bus.ULASrcA    = rst_n & ula_src_a;
    assign bus.Branch     = rst_n & branch;
    assign bus.RegDst     = rst_n ? reg_dst     : 2'b00;
    assign bus.MemtoReg   = rst_n ? mem_to_reg  : 2'b00;
    assign bus.ULASrcB    = rst_n ? ula_src_b   : 2'b00;
    assign bus.PCSrc      = rst_n ? pc_src      : 2'b00;
    assign bus.ULAControl = rst_n ? ula_control : 3'b000;
    assign bus.state      = rst_n ? state_q     : 4'd0;
    assign bus.done       = rst_n & done;
    assign bus.illegal    = rst_n & (state_q == S_ILLEGAL);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Three control units with MEM_WAIT = 0, 2 and 3, each with its own reset
// and instruction fields. All outputs of an instance are packed into one
// 24-bit word and compared against hand-built expected words:
//   {PCWrite,IorD,IRWrite,MemWrite,RegWrite,ULASrcA,Branch,
//    RegDst,MemtoReg,ULASrcB,PCSrc,ULAControl,state,done,illegal}
// Inputs change just after a rising edge or at a falling edge; outputs are
// sampled at falling edges.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic       clk;
    logic [2:0] rst_n_v;
    logic [5:0] op_v    [3];
    logic [5:0] funct_v [3];
    logic [23:0] obs    [3];

    int checks = 0;
    int errors = 0;
    bit mw_seen2 = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_control_unit_if bus ();
        assign bus.OP    = op_v[g];
        assign bus.Funct = funct_v[g];
        assign obs[g] = {bus.PCWrite, bus.IorD, bus.IRWrite, bus.MemWrite,
                         bus.RegWrite, bus.ULASrcA, bus.Branch,
                         bus.RegDst, bus.MemtoReg, bus.ULASrcB, bus.PCSrc,
                         bus.ULAControl, bus.state, bus.done, bus.illegal};
        multicycle_control_unit #(
            .MEM_WAIT((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n_v[g]),
            .bus   (bus)
        );
    end

    // MemWrite of the MEM_WAIT=3 instance must never rise during the aborted store.
    always @(posedge clk) if (obs[2][20] === 1'b1) mw_seen2 = 1'b1;

    function automatic logic [23:0] ctl(
        input logic pcw, iord, irw, memw, regw, srca, br,
        input logic [1:0] regdst, m2r, srcb, pcsrc,
        input logic [2:0] alu, input logic [3:0] st, input logic dn, ill);
        return {pcw, iord, irw, memw, regw, srca, br, regdst, m2r, srcb, pcsrc, alu, st, dn, ill};
    endfunction

    function automatic logic [23:0] e_fetch(input logic last);
        return ctl(last,0,last,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 3'b010, 4'd0, 0,0);
    endfunction
    function automatic logic [23:0] e_decode();
        return ctl(0,0,0,0,0,0,0, 2'b00,2'b00,2'b11,2'b00, 3'b010, 4'd1, 0,0);
    endfunction
    function automatic logic [23:0] e_memadr();
        return ctl(0,0,0,0,0,1,0, 2'b00,2'b00,2'b10,2'b00, 3'b010, 4'd2, 0,0);
    endfunction
    function automatic logic [23:0] e_memread();
        return ctl(0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 4'd3, 0,0);
    endfunction
    function automatic logic [23:0] e_memwb();
        return ctl(0,0,0,0,1,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b000, 4'd4, 1,0);
    endfunction
    function automatic logic [23:0] e_memwrite(input logic last);
        return ctl(0,1,0,last,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 4'd5, last,0);
    endfunction
    function automatic logic [23:0] e_exec(input logic [2:0] alu);
        return ctl(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, alu, 4'd6, 0,0);
    endfunction
    function automatic logic [23:0] e_aluwb();
        return ctl(0,0,0,0,1,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b000, 4'd7, 1,0);
    endfunction
    function automatic logic [23:0] e_branch();
        return ctl(0,0,0,0,0,1,1, 2'b00,2'b00,2'b00,2'b01, 3'b110, 4'd8, 1,0);
    endfunction
    function automatic logic [23:0] e_addiex();
        return ctl(0,0,0,0,0,1,0, 2'b00,2'b00,2'b10,2'b00, 3'b010, 4'd9, 0,0);
    endfunction
    function automatic logic [23:0] e_addiwb();
        return ctl(0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 4'd10, 1,0);
    endfunction
    function automatic logic [23:0] e_jump();
        return ctl(1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b10, 3'b000, 4'd11, 1,0);
    endfunction
    function automatic logic [23:0] e_illegal();
        return ctl(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 4'd15, 0,1);
    endfunction
`ifdef JAL_JR_EN
    function automatic logic [23:0] e_jal();
        return ctl(1,0,0,0,1,0,0, 2'b10,2'b01,2'b00,2'b10, 3'b000, 4'd12, 1,0);
    endfunction
    function automatic logic [23:0] e_jr();
        return ctl(1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b11, 3'b000, 4'd13, 1,0);
    endfunction
`endif

    task automatic chk(input int k, input logic [23:0] exp, input string tag);
        checks++;
        assert (obs[k] === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d observed=%h expected=%h", tag, k, obs[k], exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Release reset just after a rising edge; returns in FETCH cycle 1.
    task automatic release_rst(input int k);
        @(posedge clk);
        #1 rst_n_v[k] = 1'b1;
        @(negedge clk);
    endtask

    // Called at a falling edge: assert reset, check outputs are low, release.
    task automatic pulse_rst(input int k, input string tag);
        rst_n_v[k] = 1'b0;
        #1 chk(k, 24'h0, tag);
        @(posedge clk);
        #1 rst_n_v[k] = 1'b1;
        @(negedge clk);
    endtask

    logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    logic [2:0] alu_tab [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b011,    3'b111};

    initial begin
        rst_n_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            op_v[i]    = 6'b000000;
            funct_v[i] = 6'b100000;
        end
        repeat (2) @(negedge clk);
        chk(0, 24'h0, "reset_out_w0");
        chk(1, 24'h0, "reset_out_w2");
        chk(2, 24'h0, "reset_out_w3");

        // ---------------- MEM_WAIT = 0 ----------------
        // add: 4 cycles
        release_rst(0);
        chk(0, e_fetch(1), "add_fetch");
        step(); chk(0, e_decode(), "add_decode");
        step(); chk(0, e_exec(3'b010), "add_exec");
        step(); chk(0, e_aluwb(), "add_aluwb");
        step(); chk(0, e_fetch(1), "add_next_fetch");

        // remaining R-type operations
        for (int i = 1; i < 6; i++) begin
            funct_v[0] = fn_tab[i];
            step(); chk(0, e_decode(), "rtype_decode");
            step(); chk(0, e_exec(alu_tab[i]), "rtype_exec");
            step(); chk(0, e_aluwb(), "rtype_aluwb");
            step(); chk(0, e_fetch(1), "rtype_next_fetch");
        end

        // beq: 3 cycles
        op_v[0] = 6'b000100;
        step(); chk(0, e_decode(), "beq_decode");
        step(); chk(0, e_branch(), "beq_branch");
        step(); chk(0, e_fetch(1), "beq_next_fetch");

        // addi: 4 cycles
        op_v[0] = 6'b001000;
        step(); chk(0, e_decode(), "addi_decode");
        step(); chk(0, e_addiex(), "addi_ex");
        step(); chk(0, e_addiwb(), "addi_wb");
        step(); chk(0, e_fetch(1), "addi_next_fetch");

        // j: 3 cycles
        op_v[0] = 6'b000010;
        step(); chk(0, e_decode(), "j_decode");
        step(); chk(0, e_jump(), "j_jump");
        step(); chk(0, e_fetch(1), "j_next_fetch");

        // jal and jr
        op_v[0] = 6'b000011;
        step(); chk(0, e_decode(), "jal_decode");
`ifdef JAL_JR_EN
        step(); chk(0, e_jal(), "jal_exec");
        step(); chk(0, e_fetch(1), "jal_next_fetch");
        op_v[0] = 6'b000000; funct_v[0] = 6'b001000;
        step(); chk(0, e_decode(), "jr_decode");
        step(); chk(0, e_jr(), "jr_exec");
        step(); chk(0, e_fetch(1), "jr_next_fetch");
`else
        step(); chk(0, e_illegal(), "jal_illegal");
        step(); chk(0, e_illegal(), "jal_illegal_hold");
        pulse_rst(0, "jal_reset_out");
        chk(0, e_fetch(1), "jal_reset_fetch");
        op_v[0] = 6'b000000; funct_v[0] = 6'b001000;
        step(); chk(0, e_decode(), "jr_decode");
        step(); chk(0, e_illegal(), "jr_illegal");
        pulse_rst(0, "jr_reset_out");
        chk(0, e_fetch(1), "jr_reset_fetch");
`endif

        // lw: 5 cycles
        op_v[0] = 6'b100011; funct_v[0] = 6'b100000;
        step(); chk(0, e_decode(), "lw0_decode");
        step(); chk(0, e_memadr(), "lw0_memadr");
        step(); chk(0, e_memread(), "lw0_memread");
        step(); chk(0, e_memwb(), "lw0_memwb");
        step(); chk(0, e_fetch(1), "lw0_next_fetch");

        // sw: 4 cycles
        op_v[0] = 6'b101011;
        step(); chk(0, e_decode(), "sw0_decode");
        step(); chk(0, e_memadr(), "sw0_memadr");
        step(); chk(0, e_memwrite(1), "sw0_memwrite");
        step(); chk(0, e_fetch(1), "sw0_next_fetch");

        // unknown opcode: trap held 10 cycles, cleared by reset
        op_v[0] = 6'b111111;
        step(); chk(0, e_decode(), "bad_decode");
        for (int i = 0; i < 10; i++) begin
            step(); chk(0, e_illegal(), "bad_illegal_hold");
        end
        op_v[0] = 6'b000000; funct_v[0] = 6'b100000;
        pulse_rst(0, "bad_reset_out");
        chk(0, e_fetch(1), "bad_reset_fetch");
        step(); chk(0, e_decode(), "bad_reset_decode");

        // ---------------- MEM_WAIT = 2: lw, 9 cycles ----------------
        op_v[1] = 6'b100011;
        release_rst(1);
        chk(1, e_fetch(0), "lw2_fetch1");
        step(); chk(1, e_fetch(0), "lw2_fetch2");
        step(); chk(1, e_fetch(1), "lw2_fetch3");
        step(); chk(1, e_decode(), "lw2_decode");
        step(); chk(1, e_memadr(), "lw2_memadr");
        for (int i = 0; i < 3; i++) begin
            step(); chk(1, e_memread(), "lw2_memread");
        end
        step(); chk(1, e_memwb(), "lw2_memwb");
        step(); chk(1, e_fetch(0), "lw2_next_fetch");

        // ---------------- MEM_WAIT = 3: sw aborted by reset ----------------
        op_v[2] = 6'b101011;
        release_rst(2);
        chk(2, e_fetch(0), "sw3_fetch1");
        step(); chk(2, e_fetch(0), "sw3_fetch2");
        step(); chk(2, e_fetch(0), "sw3_fetch3");
        step(); chk(2, e_fetch(1), "sw3_fetch4");
        step(); chk(2, e_decode(), "sw3_decode");
        step(); chk(2, e_memadr(), "sw3_memadr");
        step(); chk(2, e_memwrite(0), "sw3_memwrite1");
        @(posedge clk);
        #1 rst_n_v[2] = 1'b0;
        @(negedge clk); chk(2, 24'h0, "sw3_reset_out1");
        step(); chk(2, 24'h0, "sw3_reset_out2");
        release_rst(2);
        chk(2, e_fetch(0), "sw3_restart_fetch1");
        step(); chk(2, e_fetch(0), "sw3_restart_fetch2");
        step(); chk(2, e_fetch(0), "sw3_restart_fetch3");
        step(); chk(2, e_fetch(1), "sw3_restart_fetch4");

        checks++;
        assert (mw_seen2 === 1'b0) else begin
            errors++;
            $error("FAIL sw3_memwrite_never observed=%0b expected=0", mw_seen2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, meaning extra wait cycles per memory access (range 0..15).
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset (synchronous, active-low).
REQ-004 SHALL have ports OP, input, 6, and Funct, input, 6, taken from the external instruction register and stable from DECODE to end of instruction.
REQ-005 SHALL have 1-bit outputs PCWrite, IorD, IRWrite, MemWrite, RegWrite, ULASrcA, Branch: the datapath write enables and mux selects.
REQ-006 SHALL have 2-bit outputs RegDst (00 rt, 01 rd, 10 $ra), MemtoReg (00 ULA, 10 mem, 01 PC), ULASrcB (00 reg, 01 const 4, 10 imm, 11 imm<<2), PCSrc (00 ULA, 01 ULAOut, 10 jump target, 11 register).
REQ-007 SHALL have output ULAControl, 3 bits: 010 add, 110 sub, 000 and, 001 or, 011 nor, 111 slt.
REQ-008 SHALL have outputs state, 4 bits (current state code, for debug LEDs); done, 1 bit (last cycle of each instruction); illegal, 1 bit (sticky).

Function
REQ-009 SHALL be a Moore FSM; every output not listed for a state SHALL be 0 (no don't-cares driven).
REQ-010 Wait counter: FETCH, MEMREAD and MEMWRITE SHALL each last MEM_WAIT+1 cycles; IRWrite/PCWrite/MemWrite SHALL assert only on the final cycle; counter clears on leaving the state.
REQ-011 FETCH: IorD=0, ULASrcA=0, ULASrcB=01, ULAControl=010, PCSrc=00, IRWrite=PCWrite=1 on final cycle; next DECODE.
REQ-012 DECODE: ULASrcA=0, ULASrcB=11, ULAControl=010; next chosen from OP/Funct per REQ-013.
REQ-013 Decode map: 100011/101011 -> MEMADR; 000000 with Funct 100000/100010/100100/100101/100111/101010 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; 000011 -> JAL; 000000/001000 -> JR; any other -> ILLEGAL.
REQ-014 MEMADR: ULASrcA=1, ULASrcB=10, add; next MEMREAD if OP=100011, else MEMWRITE.
REQ-015 MEMREAD: IorD=1; next MEMWB. MEMWB: RegWrite=1, RegDst=00, MemtoReg=10.
REQ-016 MEMWRITE: IorD=1, MemWrite per REQ-010.
REQ-017 EXECUTE: ULASrcA=1, ULASrcB=00, ULAControl from Funct per REQ-007 order; next ALUWB: RegWrite=1, RegDst=01, MemtoReg=00.
REQ-018 ADDIEX: ULASrcA=1, ULASrcB=10, add; next ADDIWB: RegWrite=1, RegDst=00, MemtoReg=00.
REQ-019 BRANCH: ULASrcA=1, ULASrcB=00, ULAControl=110, Branch=1, PCSrc=01.
REQ-020 JUMP: PCWrite=1, PCSrc=10. JAL: PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, MemtoReg=01. JR: PCWrite=1, PCSrc=11.
REQ-021 MEMWB, MEMWRITE (final cycle), ALUWB, ADDIWB, BRANCH, JUMP, JAL, JR SHALL assert done and return to FETCH.
REQ-022 ILLEGAL: all enables 0, illegal=1, state held until reset.
REQ-023 Latencies with MEM_WAIT=W: lw 5+2W, sw 4+2W, R-type/addi 4+W, beq/j/jal/jr 3+W cycles.

Reset
REQ-024 While rst_n=0 at a clk edge: state<=FETCH, counter<=0, illegal<=0; all outputs SHALL be 0 while rst_n=0.
REQ-025 Reset mid-instruction SHALL abort it with no further write enable asserted; fetch restarts the cycle after rst_n rises.

Configuration
REQ-026 Macro JAL_JR_EN defined: JAL and JR states exist per REQ-013/020.
REQ-027 JAL_JR_EN undefined: OP 000011 and JR encoding SHALL go to ILLEGAL; RegDst=10, MemtoReg=01, PCSrc=11 never produced.

Verification
REQ-028 MEM_WAIT=0, add (000000/100000) -> FETCH,DECODE,EXECUTE(ULAControl=010),ALUWB(RegWrite=1,RegDst=01,done=1); 4 cycles.
REQ-029 MEM_WAIT=2, lw -> IRWrite only on 3rd FETCH cycle; MEMREAD 3 cycles; MEMWB RegWrite=1, MemtoReg=10; 9 cycles total.
REQ-030 beq -> BRANCH cycle ULAControl=110, Branch=1, PCSrc=01, done=1; 3 cycles.
REQ-031 jal with JAL_JR_EN -> RegWrite=1, RegDst=10, MemtoReg=01, PCSrc=10, PCWrite=1; without -> illegal=1, no enables.
REQ-032 MEM_WAIT=3, sw, rst_n=0 on 2nd MEMWRITE cycle -> MemWrite never 1; state=FETCH after reset.
REQ-033 OP=111111 -> illegal=1 held 10 cycles, all enables 0; rst_n pulse clears it.
